// File: rtl/fp8_dot_accumulator_if.sv
// Handshake bundle for the FP8 dot-product accumulator.
// Input side carries 4-lane binary16 product beats; output side carries one
// exact fixed-point sum per dot product.
interface fp8_dot_accumulator_if #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 56
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [63:0]             in_prod;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [LEN_W:0]          out_count;
    logic                    out_inf;
    logic                    out_nan;

    // Producer of beats / consumer of results
    modport master (
        output in_valid, in_last, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_inf, out_nan
    );

    // The accumulator itself
    modport slave (
        input  in_valid, in_last, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_inf, out_nan
    );
endinterface

// File: rtl/fp8_dot_accumulator.sv
// FP8 dot-product accumulator: converts each binary16 lane exactly to signed
// fixed point (units of 2^-24), sums the 4 lanes, accumulates beats until a
// last marker (or a full counter) and presents one exact sum.
// Optional feature macro: FP8ACC_SPECIALS_EN -- when defined, exponent 31
// lanes contribute 0 and raise sticky inf/nan flags; when undefined they are
// ordinary finite values and the flags are constant 0.
module fp8_dot_accumulator #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    fp8_dot_accumulator_if.slave  bus
);
    // Largest lane magnitude is 2047 << 30 (41 bits), plus sign.
    localparam int LANE_W = 42;
    localparam int SUM_W  = LANE_W + 2;
    localparam logic [LEN_W:0] COUNT_MAX = {1'b0, {LEN_W{1'b1}}};

    typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

    state_t state, state_next;
    logic   in_ready;
    logic   accept;
    logic   count_max;
    logic   flush_fire;

    logic [LEN_W:0]              count;
    logic signed [LANE_W-1:0]    lane_dec [4];
    logic [3:0]                  lane_inf;
    logic [3:0]                  lane_nan;

    logic                        s1_valid, s1_last, s1_inf, s1_nan;
    logic signed [LANE_W-1:0]    s1_lane [4];
    logic                        s2_valid, s2_last, s2_inf, s2_nan;
    logic signed [SUM_W-1:0]     s2_sum;
    logic signed [SUM_W-1:0]     lane_sum;
    logic                        s3_last;
    logic signed [ACC_W-1:0]     acc;
    logic                        acc_inf, acc_nan;

    logic                        out_valid;
    logic signed [ACC_W-1:0]     out_sum;
    logic [LEN_W:0]              out_count;
    logic                        out_inf, out_nan;

    // Exact binary16 -> fixed point: m << (max(e,1)-1), negated when sign set.
    function automatic logic signed [LANE_W-1:0] decode_lane(input logic [15:0] h);
        logic [4:0]        e;
        logic [4:0]        sh;
        logic [LANE_W-1:0] mag;
        e   = h[14:10];
        sh  = (e == 5'd0) ? 5'd0 : e - 5'd1;
        mag = {{(LANE_W-11){1'b0}}, (e != 5'd0), h[9:0]} << sh;
`ifdef FP8ACC_SPECIALS_EN
        if (e == 5'd31) mag = '0;
`endif
        decode_lane = h[15] ? -$signed(mag) : $signed(mag);
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_dec[gi] = decode_lane(bus.in_prod[16*gi +: 16]);
`ifdef FP8ACC_SPECIALS_EN
            assign lane_inf[gi] = (bus.in_prod[16*gi+10 +: 5] == 5'd31) &&
                                  (bus.in_prod[16*gi +: 10] == 10'd0);
            assign lane_nan[gi] = (bus.in_prod[16*gi+10 +: 5] == 5'd31) &&
                                  (bus.in_prod[16*gi +: 10] != 10'd0);
`else
            assign lane_inf[gi] = 1'b0;
            assign lane_nan[gi] = 1'b0;
`endif
        end
    endgenerate

    assign accept     = bus.in_valid && in_ready;
    assign count_max  = (count == COUNT_MAX);
    assign flush_fire = (state == FLUSH) && s3_last;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    // FSM next state and in_ready
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid && (bus.in_last || count_max)) state_next = FLUSH;
            end
            FLUSH: if (s3_last) state_next = HOLD;
            HOLD:  if (out_valid && bus.out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Beat counter; the beat that fills the counter is forced to be last
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             count <= '0;
        else if (flush_fire) count <= '0;
        else if (accept)     count <= count + 1'b1;
    end

    // S1: register decoded lanes with last/special flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_nan   <= 1'b0;
            for (int i = 0; i < 4; i++) s1_lane[i] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= bus.in_last || count_max;
                s1_inf  <= |lane_inf;
                s1_nan  <= |lane_nan;
                for (int i = 0; i < 4; i++) s1_lane[i] <= lane_dec[i];
            end
        end
    end

    // Four-lane reduction feeding S2
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 4; i++) lane_sum = lane_sum + SUM_W'(s1_lane[i]);
    end

    // S2: register the per-beat sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_inf   <= 1'b0;
            s2_nan   <= 1'b0;
            s2_sum   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            s2_inf   <= s1_valid && s1_inf;
            s2_nan   <= s1_valid && s1_nan;
            s2_sum   <= lane_sum;
        end
    end

    // S3: exact accumulation and sticky flags; cleared when a result is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_inf <= 1'b0;
            acc_nan <= 1'b0;
            s3_last <= 1'b0;
        end else if (flush_fire) begin
            acc     <= '0;
            acc_inf <= 1'b0;
            acc_nan <= 1'b0;
            s3_last <= 1'b0;
        end else begin
            s3_last <= s2_valid && s2_last;
            if (s2_valid) begin
                acc     <= acc + ACC_W'(s2_sum);
                acc_inf <= acc_inf | s2_inf;
                acc_nan <= acc_nan | s2_nan;
            end
        end
    end

    // Result registers: loaded once the last beat is in the accumulator, held until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_inf   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (flush_fire) begin
            out_valid <= 1'b1;
            out_sum   <= acc;
            out_count <= count;
            out_inf   <= acc_inf;
            out_nan   <= acc_nan;
        end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_count = out_count;
    assign bus.out_inf   = out_inf;
    assign bus.out_nan   = out_nan;
endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// Directed bench for fp8_dot_accumulator: one instance with LEN_W=8 and one
// with LEN_W=2 (for the counter auto-close), sharing stimulus through a select.
module tb_fp8_dot_accumulator;
    localparam int ACC_W = 56;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic in_valid;
    logic in_last;
    logic [63:0] in_prod;
    logic out_ready;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp8_dot_accumulator_if #(.LEN_W(8), .ACC_W(ACC_W)) if_a ();
    fp8_dot_accumulator_if #(.LEN_W(2), .ACC_W(ACC_W)) if_b ();

    assign if_a.in_valid  = in_valid && !sel;
    assign if_a.in_last   = in_last;
    assign if_a.in_prod   = in_prod;
    assign if_a.out_ready = out_ready && !sel;
    assign if_b.in_valid  = in_valid && sel;
    assign if_b.in_last   = in_last;
    assign if_b.in_prod   = in_prod;
    assign if_b.out_ready = out_ready && sel;

    fp8_dot_accumulator #(.LEN_W(8), .ACC_W(ACC_W)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    fp8_dot_accumulator #(.LEN_W(2), .ACC_W(ACC_W)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    logic               in_ready_m, out_valid_m, inf_m, nan_m;
    logic signed [63:0] sum_m;
    logic [8:0]         count_m;

    assign in_ready_m  = sel ? if_b.in_ready  : if_a.in_ready;
    assign out_valid_m = sel ? if_b.out_valid : if_a.out_valid;
    assign inf_m       = sel ? if_b.out_inf   : if_a.out_inf;
    assign nan_m       = sel ? if_b.out_nan   : if_a.out_nan;
    assign sum_m       = sel ? 64'($signed(if_b.out_sum)) : 64'($signed(if_a.out_sum));
    assign count_m     = sel ? {6'd0, if_b.out_count} : if_a.out_count;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Offer one beat; it is accepted on the following rising edge
    task automatic send(input logic [63:0] prod, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        check("send.in_ready", in_ready_m, 1);
        @(posedge clk);
    endtask

    // Called right after the last beat's accepting edge: checks latency,
    // result, optional stall stability, then completes the handshake.
    task automatic get_result(input string tag, input logic signed [63:0] esum,
                              input int ecount, input logic einf, input logic enan,
                              input int stall, input logic offer);
        int k;
        k = 0;
        @(negedge clk);
        in_valid = offer;
        in_last  = 1'b0;
        in_prod  = 64'h3C00_3C00_3C00_3C00;
        check({tag, ".rdy_low"}, in_ready_m, 0);
        while (!out_valid_m && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".latency"}, k, 3);
        check({tag, ".sum"}, sum_m, esum);
        check({tag, ".count"}, count_m, ecount);
        check({tag, ".inf"}, inf_m, einf);
        check({tag, ".nan"}, nan_m, enan);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, out_valid_m, 1);
            check({tag, ".hold_sum"}, sum_m, esum);
            check({tag, ".hold_inf"}, inf_m, einf);
            check({tag, ".hold_rdy"}, in_ready_m, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check({tag, ".valid_clr"}, out_valid_m, 0);
        check({tag, ".rdy_back"}, in_ready_m, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [63:0] special_sum;
        logic               special_flag;
`ifdef FP8ACC_SPECIALS_EN
        special_sum  = 64'sd2 * 64'sd16777216;
        special_flag = 1'b1;
`else
        // 2 * 2^24 from the two 1.0 lanes, 1024<<30 (0x7C00) and 1536<<30 (0x7E00)
        special_sum  = 64'sd33554432 + 64'sd1099511627776 + 64'sd1649267441664;
        special_flag = 1'b0;
`endif
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_prod = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset.in_ready", in_ready_m, 1);
            check("reset.out_valid", out_valid_m, 0);
            check("reset.sum", sum_m, 0);
            check("reset.count", count_m, 0);
            check("reset.inf", inf_m, 0);
            check("reset.nan", nan_m, 0);
        end
        sel = 1'b0;

        // -6 + 3 - 4.5 + 1.25 = -6.25
        send(64'hC600_4200_C480_3D00, 1'b1);
        get_result("mixed", -64'sd104857600, 1, 1'b0, 1'b0, 0, 1'b0);

        // 4.0 then (-1 + 2) back to back
        send(64'h3C00_3C00_3C00_3C00, 1'b0);
        send(64'hBC00_0000_0000_4000, 1'b1);
        get_result("two_beat", 64'sd83886080, 2, 1'b0, 1'b0, 0, 1'b0);

        send(64'h0001_0001_0001_0001, 1'b1);
        get_result("subnormal", 64'sd4, 1, 1'b0, 1'b0, 0, 1'b0);

        send(64'h8000_0000_0000_0000, 1'b1);
        get_result("neg_zero", 64'sd0, 1, 1'b0, 1'b0, 0, 1'b0);

        // Specials, with a 5-cycle consumer stall and a beat offered during HOLD
        send(64'h3C00_3C00_7E00_7C00, 1'b1);
        get_result("specials", special_sum, 1, special_flag, special_flag, 5, 1'b1);

        // Next sum must be clean: count 1 proves the HOLD beat was not taken
        send(64'h0000_0000_0000_3C00, 1'b1);
        get_result("clean", 64'sd16777216, 1, 1'b0, 1'b0, 0, 1'b0);

        // LEN_W=2: fourth beat auto-closes the sum
        sel = 1'b1;
        for (int b = 0; b < 4; b++) send(64'h3C00_3C00_3C00_3C00, 1'b0);
        get_result("auto_close", 64'sd268435456, 4, 1'b0, 1'b0, 0, 1'b0);

        // Reset while flushing discards the pending sum
        send(64'h4000_4000_4000_4000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_flush.no_valid", out_valid_m, 0);
        end
        check("rst_flush.in_ready", in_ready_m, 1);
        check("rst_flush.sum", sum_m, 0);
        send(64'h0000_0000_0000_3C00, 1'b1);
        get_result("after_rst", 64'sd16777216, 1, 1'b0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
